// File: rtl/ysyx_22040125_wb_regfile_pkg.sv
// Shared core constants for the writeback stage: result-source selects and
// load width/sign codes (RV64 funct3 encodings for loads).
package ysyx_22040125_wb_regfile_pkg;

  localparam int XLEN = 64;

  // Writeback source select
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_CSR  = 2'b11;

  // Load funct3 codes
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_LWU  = 3'b110;
  localparam logic [2:0] F3_LDU  = 3'b111;

endpackage

// File: rtl/ysyx_22040125_wb_regfile_load_ext.sv
// Load data extraction: takes memory data already aligned to bit 0 and
// trims/extends it to 64 bits according to the load funct3 code.
module ysyx_22040125_LOAD_EXT
  import ysyx_22040125_wb_regfile_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  // Select width and sign/zero extension
  always_comb begin
    result = data;
    case (funct3)
      F3_LB:   result = {{56{data[7]}},  data[7:0]};
      F3_LH:   result = {{48{data[15]}}, data[15:0]};
      F3_LW:   result = {{32{data[31]}}, data[31:0]};
      F3_LD:   result = data;
      F3_LBU:  result = {56'd0, data[7:0]};
      F3_LHU:  result = {48'd0, data[15:0]};
      F3_LWU:  result = {32'd0, data[31:0]};
      F3_LDU:  result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ysyx_22040125_wb_regfile.sv
// Writeback stage + integer register file. Selects the writeback value,
// writes x1..x31, serves two combinational read ports with same-cycle
// write-through, records a registered retire record and counts retirements.
module ysyx_22040125_wb_regfile
  import ysyx_22040125_wb_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic [2:0]      wb_funct3,
  input  logic            wb_we,
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [4:0]      wb_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic [XLEN-1:0] retire_cnt
);

  // x0 is not stored; it is hardwired to zero on the read side
  logic [XLEN-1:0] regs [31:1];
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_value;
  logic            wr_en;

  ysyx_22040125_LOAD_EXT u_load_ext (
    .data   (wb_mem_data),
    .funct3 (wb_funct3),
    .result (load_val)
  );

  // A real write needs reset released, a live instruction, and a non-x0 target
  assign wr_en = rst && wb_valid && wb_we && (wb_rd != 5'd0);

  // Writeback source mux; link address wraps naturally at 2^64
  always_comb begin
    wb_value = wb_alu;
    case (wb_sel)
      WB_SEL_ALU:  wb_value = wb_alu;
      WB_SEL_LOAD: wb_value = load_val;
      WB_SEL_LINK: wb_value = wb_pc + 64'd4;
      WB_SEL_CSR:  wb_value = wb_alu;
      default:     wb_value = wb_alu;
    endcase
  end

  // Read port 1: zero in reset or for x0, else bypass the pending write
  always_comb begin
    rs1_data = '0;
    if (rst && (rs1_addr != 5'd0)) begin
      if (wr_en && (rs1_addr == wb_rd)) rs1_data = wb_value;
      else                              rs1_data = regs[rs1_addr];
    end
  end

  // Read port 2: same policy as port 1, fully independent
  always_comb begin
    rs2_data = '0;
    if (rst && (rs2_addr != 5'd0)) begin
      if (wr_en && (rs2_addr == wb_rd)) rs2_data = wb_value;
      else                              rs2_data = regs[rs2_addr];
    end
  end

  // Register array: clear on reset, otherwise take the qualified write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_value;
    end
  end

  // Retire record: valid pulses for each WB instruction, fields hold on bubbles
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
    end else if (wb_valid) begin
      commit_valid <= 1'b1;
      commit_pc    <= wb_pc;
      commit_rd    <= wb_we ? wb_rd : 5'd0;
      commit_data  <= wr_en ? wb_value : '0;
    end else begin
      commit_valid <= 1'b0;
    end
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk) begin
    if (!rst)          retire_cnt <= '0;
    else if (wb_valid) retire_cnt <= retire_cnt + 64'd1;
  end

endmodule

// File: tb/tb_ysyx_22040125_wb_regfile.sv
// Directed bench for the writeback/register-file block.
module tb_ysyx_22040125_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [63:0] wb_mem_data;
  logic [2:0]  wb_funct3;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [63:0] wb_alu;
  logic [63:0] wb_pc;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [63:0] commit_data;
  logic [63:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22040125_wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_mem_data  (wb_mem_data),
    .wb_funct3    (wb_funct3),
    .wb_we        (wb_we),
    .wb_sel       (wb_sel),
    .wb_alu       (wb_alu),
    .wb_pc        (wb_pc),
    .wb_rd        (wb_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .retire_cnt   (retire_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem,
                       input logic [63:0] pc);
    wb_valid    = v;
    wb_we       = we;
    wb_sel      = sel;
    wb_funct3   = f3;
    wb_rd       = rd;
    wb_alu      = alu;
    wb_mem_data = mem;
    wb_pc       = pc;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 64'd0, 64'd0, 64'd0);
  endtask

  logic [2:0]  lt_f3  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [63:0] lt_exp [8] = '{64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_C380,
                              64'hFFFF_FFFF_89AB_C380, 64'hF234_5678_89AB_C380,
                              64'h0000_0000_0000_0080, 64'h0000_0000_0000_C380,
                              64'h0000_0000_89AB_C380, 64'hF234_5678_89AB_C380};
  logic        cv_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    // Reset with a live write attempt: nothing may land
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 64'h55, 64'd0, 64'h100);
    rs1_addr = 5'd5; #1;
    chk("rst_read_zero", rs1_data, 64'd0);
    step();
    step();
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_commit_pc", commit_pc, 64'd0);
    chk("rst_commit_rd", {59'd0, commit_rd}, 64'd0);
    chk("rst_commit_data", commit_data, 64'd0);
    chk("rst_retire_cnt", retire_cnt, 64'd0);
    rst = 1'b1;
    bubble();
    chk("rst_x5_zero", rs1_data, 64'd0);

    // Load extraction on the 0x80 byte, signed then unsigned
    drive(1'b1, 1'b1, 2'b01, 3'b000, 5'd5, 64'd0, 64'h80, 64'h200);
    chk("lb_bypass", rs1_data, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    chk("lb_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("lb_commit_data", commit_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_commit_pc", commit_pc, 64'h200);
    chk("lb_retire", retire_cnt, 64'd1);
    bubble();
    chk("lb_array", rs1_data, 64'hFFFF_FFFF_FFFF_FF80);
    drive(1'b1, 1'b1, 2'b01, 3'b100, 5'd5, 64'd0, 64'h80, 64'h204);
    step();
    bubble();
    chk("lbu_array", rs1_data, 64'h80);

    // All eight load codes into x6, observed through read port 2
    rs2_addr = 5'd6;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b01, lt_f3[i], 5'd6, 64'd0, 64'hF234_5678_89AB_C380, 64'h300);
      chk($sformatf("load_f3_%0d_bypass", i), rs2_data, lt_exp[i]);
      step();
      bubble();
      chk($sformatf("load_f3_%0d_array", i), rs2_data, lt_exp[i]);
    end

    // Same-cycle write-through to both ports
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 64'h1234, 64'd0, 64'h400);
    chk("byp_rs1", rs1_data, 64'h1234);
    chk("byp_rs2", rs2_data, 64'h1234);
    step();
    bubble();
    chk("byp_rs1_array", rs1_data, 64'h1234);
    chk("byp_rs2_array", rs2_data, 64'h1234);

    // Write to x0: discarded, but still commits and counts (retire now 12)
    rs1_addr = 5'd0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 64'hDEAD, 64'd0, 64'h500);
    chk("x0_read", rs1_data, 64'd0);
    step();
    chk("x0_commit_rd", {59'd0, commit_rd}, 64'd0);
    chk("x0_commit_data", commit_data, 64'd0);
    chk("x0_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("x0_retire", retire_cnt, 64'd12);
    rs1_addr = 5'd7;
    bubble();
    chk("x0_no_side_effect", rs1_data, 64'h1234);

    // we without valid: no write, no bypass, no commit, no count
    drive(1'b0, 1'b1, 2'b00, 3'b000, 5'd7, 64'hBAD, 64'd0, 64'h600);
    chk("novalid_no_bypass", rs1_data, 64'h1234);
    step();
    chk("novalid_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("novalid_commit_pc_hold", commit_pc, 64'h500);
    chk("novalid_retire", retire_cnt, 64'd12);
    bubble();
    chk("novalid_no_write", rs1_data, 64'h1234);

    // JAL link values, including wrap at 2^64
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 64'd0, 64'd0, 64'h8000_0000);
    step();
    chk("jal_commit_data", commit_data, 64'h8000_0004);
    chk("jal_commit_rd", {59'd0, commit_rd}, 64'd1);
    drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("jal_wrap_commit_pc", commit_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bubble();
    chk("jal_x1", rs1_data, 64'h8000_0004);
    chk("jal_wrap_x2", rs2_data, 64'd0);

    // sel=11 takes the ALU/CSR value; we=0 with valid commits rd 0
    rs1_addr = 5'd9;
    drive(1'b1, 1'b1, 2'b11, 3'b000, 5'd9, 64'hC5C5, 64'hFFFF, 64'h700);
    step();
    bubble();
    chk("sel11_x9", rs1_data, 64'hC5C5);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 5'd9, 64'h1111, 64'd0, 64'h704);
    step();
    chk("nowe_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("nowe_commit_rd", {59'd0, commit_rd}, 64'd0);
    chk("nowe_commit_data", commit_data, 64'd0);
    bubble();
    chk("nowe_x9_kept", rs1_data, 64'hC5C5);

    // Mid-run reset: x3=5, retire=9, then one reset cycle with a live write
    rst = 1'b0; bubble(); step(); rst = 1'b1;
    rs1_addr = 5'd3;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 64'd5, 64'd0, 64'h800);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 64'd0, 64'd0, 64'h804 + 64'(4 * i));
      step();
    end
    bubble();
    chk("mid_x3_pre", rs1_data, 64'd5);
    chk("mid_retire_pre", retire_cnt, 64'd9);
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 64'd7, 64'd0, 64'h900);
    chk("mid_rst_read_zero", rs1_data, 64'd0);
    step();
    rst = 1'b1;
    bubble();
    chk("mid_x3_cleared", rs1_data, 64'd0);
    chk("mid_retire_cleared", retire_cnt, 64'd0);
    chk("mid_commit_valid", {63'd0, commit_valid}, 64'd0);
    step();
    chk("mid_no_late_commit", {63'd0, commit_valid}, 64'd0);
    chk("mid_commit_pc_zero", commit_pc, 64'd0);

    // Counter: 3 valid, 1 bubble, 2 valid
    for (int i = 0; i < 6; i++) begin
      if (cv_exp[i]) drive(1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 64'd0, 64'd0, 64'hA00 + 64'(4 * i));
      else           bubble();
      step();
      chk($sformatf("cnt_commit_valid_%0d", i), {63'd0, commit_valid}, {63'd0, cv_exp[i]});
    end
    chk("cnt_retire_5", retire_cnt, 64'd5);
    bubble();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
